// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory controller.
//   - request size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD)
//   - controller FSM state type dmem_state_t
//   - error-cause bit positions and vector type
//   - lane_mask():   byte lanes touched by an access of a given size
//   - extend_load(): sign/zero extension of assembled load data
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Each bit of the cause vector flags one independent reason for rejecting
  // an access; the controller reports their OR on rsp_error.
  localparam int ERR_W     = 3;
  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_SIZE  = 2;
  typedef logic [ERR_W-1:0] err_cause_t;

  // Lane i is the byte at (base address + i).
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001;
      SZ_HALF: lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // raw holds the loaded value right-justified; word loads ignore uns.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns);
    case (size)
      SZ_BYTE: extend_load = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: extend_load = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: plain 2**ADDR_WIDTH x 8 storage, no reset.
//   clock  in   rising-edge write clock
//   addr   in   base byte address of the 4-byte window
//   we     in   per-lane write enables, lane i writes addr+i
//   wdata  in   lane i data in wdata[8*i +: 8]
//   rdata  out  asynchronous read, lane i = mem[addr+i]
// Lane addresses wrap modulo the array depth.
module dmem_byte_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  // Write the enabled lanes on the rising edge; unwritten bytes keep their value.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr + ADDR_WIDTH'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Combinational read of the four bytes starting at addr.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[addr + ADDR_WIDTH'(i)];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte/half/word data memory controller with a valid/ready
// request handshake, WAIT_STATES wait cycles and a registered one-cycle response.
//   clock, reset_n         clock and asynchronous active-low reset
//   req_valid/req_ready    request handshake; ready only in IDLE
//   req_write, req_size    store/load and access size (11 is an error)
//   req_unsigned           zero-extend sub-word loads
//   req_addr, req_wdata    byte address, right-justified store data
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_error   extended load data (0 for stores/errors), error flag
//   busy                   high in WAIT and RESP
// Build option: define DMEM_MISALIGN_EXC_EN to report misaligned half/word
// accesses as errors; otherwise they are silently aligned down.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state, next_state;
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        enter_resp;

  logic        cap_write, cap_unsigned;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_wdata;

  logic        cur_write, cur_unsigned;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;

  err_cause_t            err_cause;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [3:0]            mask;
  logic [3:0]            arr_we;
  logic [31:0]           lane_wdata, arr_rdata, raw_load;

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; with no wait states an accepted request goes straight to RESP.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the state register only.
  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  // Wait counter: loaded on acceptance, counts down while in WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Request capture; the fields are held for the rest of the transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_write    <= 1'b0;
      cap_size     <= SZ_BYTE;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
    end else if (accept) begin
      cap_write    <= req_write;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

  // In IDLE the live request drives the datapath so a zero-wait access can
  // complete on its accepting edge; otherwise the captured copy is used.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_write    = req_write;
      cur_size     = req_size;
      cur_unsigned = req_unsigned;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
    end else begin
      cur_write    = cap_write;
      cur_size     = cap_size;
      cur_unsigned = cap_unsigned;
      cur_addr     = cap_addr;
      cur_wdata    = cap_wdata;
    end
  end

  // Error checks and base address; misaligned accesses are either rejected
  // or have their low address bits forced to zero.
  always_comb begin
    err_cause            = '0;
    err_cause[ERR_RANGE] = ((cur_addr >> ADDR_WIDTH) != 32'd0);
    err_cause[ERR_SIZE]  = (cur_size == SZ_RSVD);
    base_addr            = cur_addr[ADDR_WIDTH-1:0];
`ifdef DMEM_MISALIGN_EXC_EN
    err_cause[ERR_ALIGN] = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                           ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
`else
    if (cur_size == SZ_HALF) base_addr[0]   = 1'b0;
    if (cur_size == SZ_WORD) base_addr[1:0] = 2'b00;
`endif
  end

  // Lane steering. Value byte src lands in lane i; for big-endian the most
  // significant byte of the access goes to the lowest address. The mapping is
  // a permutation of 0..3, so zeroing disabled lanes never clobbers a live one.
  always_comb begin
    logic [1:0] src;
    int         nbytes;
    src        = 2'd0;
    lane_wdata = '0;
    raw_load   = '0;
    mask       = lane_mask(cur_size);
    nbytes     = (cur_size == SZ_BYTE) ? 1 : (cur_size == SZ_HALF) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      src = (BIG_ENDIAN != 0) ? 2'(nbytes - 1 - i) : 2'(i);
      lane_wdata[8*i +: 8] = cur_wdata[8*src +: 8];
      raw_load[8*src +: 8] = mask[i] ? arr_rdata[8*i +: 8] : 8'h00;
    end
  end

  assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);
  assign arr_we     = mask & {4{enter_resp && cur_write && (err_cause == '0) && reset_n}};

  dmem_byte_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clock (clock),
    .addr  (base_addr),
    .we    (arr_we),
    .wdata (lane_wdata),
    .rdata (arr_rdata)
  );

  // Response registers, loaded on the same edge that performs the array access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (enter_resp) begin
      rsp_error <= |err_cause;
      rsp_rdata <= (cur_write || (err_cause != '0)) ? 32'h0
                   : extend_load(raw_load, cur_size, cur_unsigned);
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the MIPS core's byte-addressed data memory.
- Adds byte/half/word accesses with sign or zero extension on loads, and a valid/ready request handshake.
- Adds configurable wait-state latency, a registered response, and out-of-range/misalignment error reporting.
- Sits between the MEM pipeline stage and the byte array; the stage stalls while busy is high.

Parameters:
- ADDR_WIDTH, 10, byte-address bits actually decoded; array depth is 2**ADDR_WIDTH bytes.
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).
- BIG_ENDIAN, 1, 1: the byte at the lowest address is the MSB of the word; 0: it is the LSB.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 store, 0 load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse, response present.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  qualified by rsp_valid: out-of-range, misaligned or reserved size.
- busy  out  1  high from the cycle after acceptance through the RESP cycle.

Behaviour:
- Reset (async, reset_n low): FSM to IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0.
- Reset does not clear the memory array. Reset mid-operation aborts the transaction; a pending store is discarded and no response is issued.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req_valid&&req_ready, capture all req_* fields. Go to WAIT with counter=WAIT_STATES-1, or go straight to RESP if WAIT_STATES==0.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: hold rsp_valid for exactly one cycle, then return to IDLE. There is no response backpressure.
- Latency: response arrives WAIT_STATES+1 cycles after the accepting edge. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Array access happens on the edge that enters RESP; rsp_rdata and rsp_error are registered on that same edge.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Error conditions: any req_addr bit at or above ADDR_WIDTH set; half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - On error: no array write, rsp_rdata=0, rsp_error=1.
- Store lanes: byte writes 1 location. Half writes addr and addr+1. Word writes addr..addr+3. Byte order follows BIG_ENDIAN. Unwritten bytes are unchanged.
- Load assembly uses the same ordering, then applies sign or zero extension to 32 bits. req_unsigned is ignored for word loads.
- A request held on req_valid while busy is not accepted; the requester holds its fields stable until acceptance.

Optional Feature:
- Macro: DMEM_MISALIGN_EXC_EN.
- Defined: misalignment is an error, as described above.
- Undefined: misaligned half/word addresses are silently aligned down (low address bits forced to 0); only out-of-range and size 11 raise rsp_error.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM state typedef dmem_state_t;
  - function for load extension;
  - error-cause constants.
- One natural sub-module, dmem_byte_array: the plain 2**ADDR_WIDTH x 8 storage with a 4-byte write-enable port and a 4-byte read port.
- The controller FSM, lane steering and error checks stay in data_memory_ctrl.

Test Plan:
- WAIT_STATES=1, BIG_ENDIAN=1: store word 0x11223344 at addr 0x10, then load word at 0x10 -> rsp_rdata 0x11223344 two cycles after acceptance, rsp_error 0.
- After that store: load byte signed at 0x13 -> 0x00000044; store byte 0xF0 at 0x11, then load half signed at 0x10 -> 0xFFFF11F0 is wrong, expected 0x000011F0; load byte signed at 0x11 -> 0xFFFFFFF0.
- Load half unsigned at 0x12 -> 0x00003344. Rerun with BIG_ENDIAN=0: word load at 0x10 after the same store -> 0x11223344, and byte load at 0x10 -> 0x00000044.
- Load word at addr 0x400 (ADDR_WIDTH=10) -> rsp_error 1, rsp_rdata 0. Store to 0x400 leaves the array unchanged.
- Word load at 0x12:
  - with DMEM_MISALIGN_EXC_EN -> rsp_error 1, rdata 0;
  - without it -> rsp_error 0, returns the word at 0x10.
- Assert reset_n while in WAIT during a store of 0xDEADBEEF to 0x20 -> no rsp_valid, req_ready=1 immediately. A later load of 0x20 returns the prior contents.
